// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port sequencer shared by the load/store buffer and instruction fetch.
// Optional MEM_ARB_IO_STALL_EN: hold IO store beats (addr[17:16]==2'b11) while io_buffer_full.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned VAL_WIDTH    = 32,
    parameter int unsigned LSB_ID_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    lsb2mem_load_en,
    input  logic                    lsb2mem_store_en,
    input  logic [ADDR_WIDTH-1:0]   lsb2mem_addr,
    input  logic [2:0]              lsb2mem_type,
    input  logic [VAL_WIDTH-1:0]    lsb2mem_val,
    input  logic [LSB_ID_WIDTH-1:0] lsb2mem_load_id,
    output logic                    mem_busy,
    output logic                    mem2lsb_load_en,
    output logic [LSB_ID_WIDTH-1:0] mem2lsb_load_id,
    output logic [VAL_WIDTH-1:0]    mem2lsb_load_val,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_done,
    output logic [VAL_WIDTH-1:0]    if_inst,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);

    typedef enum logic [1:0] {StIdle, StLoad, StStore, StFetch} state_e;

    function automatic logic [2:0] beat_count(input logic [2:0] ty);
        case (ty[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [VAL_WIDTH-1:0] extend_load(input logic [VAL_WIDTH-1:0] d,
                                                         input logic [2:0] ty);
        case (ty[1:0])
            2'b00:   return {{(VAL_WIDTH-8){d[7] & ~ty[2]}}, d[7:0]};
            2'b01:   return {{(VAL_WIDTH-16){d[15] & ~ty[2]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              type_q, type_d;
    logic [VAL_WIDTH-1:0]    val_q, val_d;
    logic [LSB_ID_WIDTH-1:0] id_q, id_d;
    logic [VAL_WIDTH-1:0]    data_q, data_d;
    logic [ADDR_WIDTH-1:0]   mem_a_q, mem_a_d;
    logic [7:0]              mem_dout_q, mem_dout_d;
    logic                    mem_wr_q, mem_wr_d;
    logic                    load_en_q, load_en_d;
    logic [LSB_ID_WIDTH-1:0] load_id_q, load_id_d;
    logic [VAL_WIDTH-1:0]    load_val_q, load_val_d;
    logic                    if_done_q, if_done_d;
    logic [VAL_WIDTH-1:0]    if_inst_q, if_inst_d;
    logic                    pend_valid_q, pend_valid_d;
    logic                    pend_store_q, pend_store_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [2:0]              pend_type_q, pend_type_d;
    logic [VAL_WIDTH-1:0]    pend_val_q, pend_val_d;
    logic [LSB_ID_WIDTH-1:0] pend_id_q, pend_id_d;

    logic                    idle, pend_eff, io_stall;
    logic                    take_pend, take_store, take_load, take_fetch, q_store, q_load;
    logic                    src_store;
    logic [ADDR_WIDTH-1:0]   src_addr;
    logic [2:0]              src_type;
    logic [VAL_WIDTH-1:0]    src_val;
    logic [LSB_ID_WIDTH-1:0] src_id;
    logic [2:0]              nb, cnt_nx;
    logic [1:0]              cap_idx;

`ifdef MEM_ARB_IO_STALL_EN
    assign io_stall = (state_q == StStore) && (mem_a_q[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign io_stall = 1'b0;
`endif

    assign idle     = (state_q == StIdle);
    // A queued load is killed by flush; a queued store is already committed and survives.
    assign pend_eff = pend_valid_q & ~(flush & ~pend_store_q);
    assign src_store = pend_eff ? pend_store_q : lsb2mem_store_en;
    assign src_addr  = pend_eff ? pend_addr_q  : lsb2mem_addr;
    assign src_type  = pend_eff ? pend_type_q  : lsb2mem_type;
    assign src_val   = pend_eff ? pend_val_q   : lsb2mem_val;
    assign src_id    = pend_eff ? pend_id_q    : lsb2mem_load_id;
    assign nb        = beat_count(type_q);
    assign cnt_nx    = cnt_q + 3'd1;
    assign cap_idx   = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        type_d       = type_q;
        val_d        = val_q;
        id_d         = id_q;
        data_d       = data_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = mem_wr_q;
        load_en_d    = load_en_q;
        load_id_d    = load_id_q;
        load_val_d   = load_val_q;
        if_done_d    = if_done_q;
        if_inst_d    = if_inst_q;
        pend_valid_d = pend_valid_q;
        pend_store_d = pend_store_q;
        pend_addr_d  = pend_addr_q;
        pend_type_d  = pend_type_q;
        pend_val_d   = pend_val_q;
        pend_id_d    = pend_id_q;
        take_pend    = 1'b0;
        take_store   = 1'b0;
        take_load    = 1'b0;
        take_fetch   = 1'b0;
        q_store      = 1'b0;
        q_load       = 1'b0;
        if (rdy_in) begin
            load_en_d  = 1'b0;
            if_done_d  = 1'b0;
            take_pend  = idle & pend_eff;
            take_store = idle & ~pend_eff & lsb2mem_store_en;
            take_load  = idle & ~pend_eff & ~lsb2mem_store_en & lsb2mem_load_en & ~flush;
            // if_req is a level still high during the if_done cycle; do not refetch then.
            take_fetch = idle & ~pend_eff & ~lsb2mem_store_en & ~lsb2mem_load_en & if_req &
                         ~if_done_q & ~flush;
            q_store    = lsb2mem_store_en & ~take_store;
            q_load     = lsb2mem_load_en & ~take_load & ~flush;
            if (~pend_eff | take_pend) begin
                pend_valid_d = q_store | q_load;
                pend_store_d = q_store;
                pend_addr_d  = lsb2mem_addr;
                pend_type_d  = lsb2mem_type;
                pend_val_d   = lsb2mem_val;
                pend_id_d    = lsb2mem_load_id;
            end
            case (state_q)
                StIdle: begin
                    if (take_pend | take_store | take_load) begin
                        state_d = src_store ? StStore : StLoad;
                        addr_d  = src_addr;
                        type_d  = src_type;
                        val_d   = src_val;
                        id_d    = src_id;
                        cnt_d   = 3'd0;
                        data_d  = '0;
                        mem_a_d = src_addr;
                        if (src_store) begin
                            mem_wr_d   = 1'b1;
                            mem_dout_d = src_val[7:0];
                        end
                    end else if (take_fetch) begin
                        state_d = StFetch;
                        addr_d  = if_addr;
                        type_d  = 3'b010;
                        cnt_d   = 3'd0;
                        data_d  = '0;
                        mem_a_d = if_addr;
                    end
                end
                StStore: begin
                    if (!io_stall) begin
                        if (cnt_q == nb - 3'd1) begin
                            state_d  = StIdle;
                            mem_wr_d = 1'b0;
                        end else begin
                            cnt_d      = cnt_nx;
                            mem_a_d    = addr_q + ADDR_WIDTH'(cnt_nx);
                            mem_dout_d = val_q[{cnt_nx[1:0], 3'b000} +: 8];
                        end
                    end
                end
                StLoad, StFetch: begin
                    if (flush) begin
                        state_d = StIdle;
                    end else begin
                        // cnt_q counts issued beats; byte cnt_q-1 is on mem_din now.
                        if (cnt_q != 3'd0) data_d[{cap_idx, 3'b000} +: 8] = mem_din;
                        if (cnt_q == nb) begin
                            state_d = StIdle;
                            if (state_q == StLoad) begin
                                load_en_d  = 1'b1;
                                load_id_d  = id_q;
                                load_val_d = extend_load(data_d, type_q);
                            end else begin
                                if_done_d = 1'b1;
                                if_inst_d = data_d;
                            end
                        end else begin
                            cnt_d = cnt_nx;
                            if (cnt_nx < nb) mem_a_d = addr_q + ADDR_WIDTH'(cnt_nx);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            type_q       <= '0;
            val_q        <= '0;
            id_q         <= '0;
            data_q       <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            load_en_q    <= 1'b0;
            load_id_q    <= '0;
            load_val_q   <= '0;
            if_done_q    <= 1'b0;
            if_inst_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_store_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_type_q  <= '0;
            pend_val_q   <= '0;
            pend_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            type_q       <= type_d;
            val_q        <= val_d;
            id_q         <= id_d;
            data_q       <= data_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            load_en_q    <= load_en_d;
            load_id_q    <= load_id_d;
            load_val_q   <= load_val_d;
            if_done_q    <= if_done_d;
            if_inst_q    <= if_inst_d;
            pend_valid_q <= pend_valid_d;
            pend_store_q <= pend_store_d;
            pend_addr_q  <= pend_addr_d;
            pend_type_q  <= pend_type_d;
            pend_val_q   <= pend_val_d;
            pend_id_q    <= pend_id_d;
        end
    end

    assign mem_busy         = ~idle | pend_valid_q;
    assign mem2lsb_load_en  = load_en_q;
    assign mem2lsb_load_id  = load_id_q;
    assign mem2lsb_load_val = load_val_q;
    assign if_done          = if_done_q;
    assign if_inst          = if_inst_q;
    assign mem_a            = mem_a_q;
    assign mem_dout         = mem_dout_q;
    assign mem_wr           = mem_wr_q & rdy_in & ~io_stall;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of loads/stores against a byte RAM model,
// plus hand sequences for arbitration, flush, stall, reset and IO hold.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic        lsb2mem_load_en, lsb2mem_store_en;
    logic [31:0] lsb2mem_addr;
    logic [2:0]  lsb2mem_type;
    logic [31:0] lsb2mem_val;
    logic [2:0]  lsb2mem_load_id;
    logic        mem_busy, mem2lsb_load_en;
    logic [2:0]  mem2lsb_load_id;
    logic [31:0] mem2lsb_load_val;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .VAL_WIDTH(32), .LSB_ID_WIDTH(3)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .lsb2mem_load_en(lsb2mem_load_en), .lsb2mem_store_en(lsb2mem_store_en),
        .lsb2mem_addr(lsb2mem_addr), .lsb2mem_type(lsb2mem_type), .lsb2mem_val(lsb2mem_val),
        .lsb2mem_load_id(lsb2mem_load_id), .mem_busy(mem_busy),
        .mem2lsb_load_en(mem2lsb_load_en), .mem2lsb_load_id(mem2lsb_load_id),
        .mem2lsb_load_val(mem2lsb_load_val), .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_inst(if_inst), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    // Byte RAM, 18-bit index; read data one cycle after address. Frozen with the system.
    logic [7:0] ram [0:262143];
    always @(posedge clk) begin
        if (rdy_in) begin
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr) begin
                ram[mem_a[17:0]] <= mem_dout;
                wr_count <= wr_count + 1;
            end
        end
    end

    typedef struct packed {
        logic        st;
        logic [31:0] addr;
        logic [2:0]  ty;
        logic [31:0] val;
        logic [2:0]  id;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    function automatic int nbytes(input logic [2:0] ty);
        return (ty[1:0] == 2'b00) ? 1 : (ty[1:0] == 2'b01) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called in cycle t (after a negedge); returns at the negedge of cycle t+1.
    task automatic lsb_issue(input logic st, input logic ld, input logic [31:0] a,
                             input logic [2:0] ty, input logic [31:0] v, input logic [2:0] id);
        lsb2mem_store_en = st;
        lsb2mem_load_en  = ld;
        lsb2mem_addr     = a;
        lsb2mem_type     = ty;
        lsb2mem_val      = v;
        lsb2mem_load_id  = id;
        @(negedge clk);
        lsb2mem_store_en = 1'b0;
        lsb2mem_load_en  = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] ty, input logic [2:0] id,
                           output logic [31:0] val, output logic [2:0] rid, output int lat);
        lsb_issue(1'b0, 1'b1, a, ty, 32'h0, id);
        lat = 1;
        while (!mem2lsb_load_en && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        val = mem2lsb_load_val;
        rid = mem2lsb_load_id;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [2:0]  rid;
        int          lat, lat_ld, lat_if, cnt, first, w0;
        logic [31:0] got_ld, got_if;

        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0;
        lsb2mem_load_en = 1'b0; lsb2mem_store_en = 1'b0; lsb2mem_addr = '0;
        lsb2mem_type = '0; lsb2mem_val = '0; lsb2mem_load_id = '0; io_buffer_full = 1'b0;
        for (int i = 0; i < 262144; i++) ram[i] <= 8'h00;
        #1;
        ram[32'h100] <= 8'h11; ram[32'h101] <= 8'h22; ram[32'h102] <= 8'h33; ram[32'h103] <= 8'h84;
        ram[0] <= 8'h01; ram[1] <= 8'h02; ram[2] <= 8'h03; ram[3] <= 8'h04;
        ram[18'h3FFFF] <= 8'hAA;

        vecs[0]  = '{1'b0, 32'h100, 3'b010, 32'h0, 3'd5, 32'h84332211};
        vecs[1]  = '{1'b0, 32'h103, 3'b000, 32'h0, 3'd1, 32'hFFFFFF84};
        vecs[2]  = '{1'b0, 32'h103, 3'b100, 32'h0, 3'd2, 32'h00000084};
        vecs[3]  = '{1'b0, 32'h102, 3'b001, 32'h0, 3'd3, 32'hFFFF8433};
        vecs[4]  = '{1'b0, 32'h102, 3'b101, 32'h0, 3'd4, 32'h00008433};
        vecs[5]  = '{1'b0, 32'h101, 3'b000, 32'h0, 3'd7, 32'h00000022};
        vecs[6]  = '{1'b1, 32'h200, 3'b001, 32'h0000ABCD, 3'd0, 32'h0};
        vecs[7]  = '{1'b0, 32'h200, 3'b001, 32'h0, 3'd0, 32'hFFFFABCD};
        vecs[8]  = '{1'b1, 32'h204, 3'b010, 32'hDEADBEEF, 3'd0, 32'h0};
        vecs[9]  = '{1'b0, 32'h204, 3'b010, 32'h0, 3'd6, 32'hDEADBEEF};
        vecs[10] = '{1'b1, 32'h208, 3'b000, 32'h12345680, 3'd0, 32'h0};
        vecs[11] = '{1'b0, 32'h208, 3'b000, 32'h0, 3'd1, 32'hFFFFFF80};
        vecs[12] = '{1'b0, 32'h1FF, 3'b101, 32'h0, 3'd2, 32'h0000CD00};
        vecs[13] = '{1'b0, 32'hFFFFFFFF, 3'b010, 32'h0, 3'd3, 32'h030201AA};

        repeat (3) @(negedge clk);
        chk("reset mem_busy", {31'b0, mem_busy}, 32'h0);
        chk("reset mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("reset mem_a", mem_a, 32'h0);
        chk("reset pulses", {30'b0, mem2lsb_load_en, if_done}, 32'h0);
        chk("reset load_val", mem2lsb_load_val, 32'h0);
        rst_in = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].st) begin
                lsb_issue(1'b1, 1'b0, vecs[i].addr, vecs[i].ty, vecs[i].val, 3'd0);
                for (int k = 0; k < nbytes(vecs[i].ty); k++) begin
                    chk($sformatf("vec%0d beat%0d wr", i, k), {31'b0, mem_wr}, 32'h1);
                    chk($sformatf("vec%0d beat%0d a", i, k), mem_a, vecs[i].addr + 32'(k));
                    v = vecs[i].val;
                    chk($sformatf("vec%0d beat%0d d", i, k), {24'b0, mem_dout}, {24'b0, v[8*k +: 8]});
                    @(negedge clk);
                end
                chk($sformatf("vec%0d busy after store", i), {31'b0, mem_busy}, 32'h0);
            end else begin
                do_load(vecs[i].addr, vecs[i].ty, vecs[i].id, v, rid, lat);
                chk($sformatf("vec%0d latency", i), 32'(lat), 32'(nbytes(vecs[i].ty) + 2));
                chk($sformatf("vec%0d val", i), v, vecs[i].exp);
                chk($sformatf("vec%0d id", i), {29'b0, rid}, {29'b0, vecs[i].id});
            end
            @(negedge clk);
        end

        // Load and fetch requested together: load first, fetch accepted as load completes.
        if_req = 1'b1; if_addr = 32'h0;
        lsb_issue(1'b0, 1'b1, 32'h100, 3'b010, 32'h0, 3'd2);
        lat_ld = 0; lat_if = 0; got_ld = '0; got_if = '0;
        for (int n = 1; n <= 20; n++) begin
            if (mem2lsb_load_en && lat_ld == 0) begin lat_ld = n; got_ld = mem2lsb_load_val; end
            if (if_done && lat_if == 0) begin lat_if = n; got_if = if_inst; if_req = 1'b0; end
            @(negedge clk);
        end
        if_req = 1'b0;
        chk("arb load latency", 32'(lat_ld), 32'd6);
        chk("arb load val", got_ld, 32'h84332211);
        chk("arb fetch latency", 32'(lat_if), 32'd12);
        chk("arb fetch inst", got_if, 32'h04030201);

        // Flush during fetch beat 2.
        if_req = 1'b1; if_addr = 32'h100; cnt = 0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("fetch flush busy", {31'b0, mem_busy}, 32'h0);
        for (int n = 0; n < 8; n++) begin
            if (if_done) cnt++;
            @(negedge clk);
        end
        chk("fetch flush no done", 32'(cnt), 32'd0);

        // Flush during a word store: all four writes still happen.
        w0 = wr_count;
        lsb_issue(1'b1, 1'b0, 32'h300, 3'b010, 32'h55667788, 3'd0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (4) @(negedge clk);
        chk("store flush writes", 32'(wr_count - w0), 32'd4);
        chk("store flush busy", {31'b0, mem_busy}, 32'h0);
        do_load(32'h300, 3'b010, 3'd1, v, rid, lat);
        chk("store flush readback", v, 32'h55667788);

        // Queued store survives a flush that aborts the active load.
        lsb_issue(1'b0, 1'b1, 32'h100, 3'b010, 32'h0, 3'd1);
        lsb_issue(1'b1, 1'b0, 32'h600, 3'b000, 32'h0000005A, 3'd0);
        flush = 1'b1; cnt = 0; first = 0;
        for (int n = 2; n <= 12; n++) begin
            if (n == 3) flush = 1'b0;
            if (mem2lsb_load_en) cnt++;
            if (mem_wr && first == 0) begin
                first = n;
                chk("pend store a", mem_a, 32'h600);
                chk("pend store d", {24'b0, mem_dout}, 32'h5A);
            end
            @(negedge clk);
        end
        chk("pend store cycle", 32'(first), 32'd4);
        chk("flushed load no pulse", 32'(cnt), 32'd0);

        // Queued load is discarded by flush.
        lsb_issue(1'b1, 1'b0, 32'h500, 3'b010, 32'h0, 3'd0);
        lsb_issue(1'b0, 1'b1, 32'h100, 3'b010, 32'h0, 3'd4);
        flush = 1'b1; cnt = 0;
        for (int n = 0; n < 14; n++) begin
            if (n == 1) flush = 1'b0;
            if (mem2lsb_load_en) cnt++;
            @(negedge clk);
        end
        chk("pend load cleared", 32'(cnt), 32'd0);
        chk("pend load busy", {31'b0, mem_busy}, 32'h0);

        // Store and load in the same cycle: store first, load from slot sees stored data.
        lsb_issue(1'b1, 1'b1, 32'h400, 3'b001, 32'h00008234, 3'd3);
        lat = 0; got_ld = '0; rid = '0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 3) chk("dual busy while queued", {31'b0, mem_busy}, 32'h1);
            if (mem2lsb_load_en && lat == 0) begin
                lat = n; got_ld = mem2lsb_load_val; rid = mem2lsb_load_id;
            end
            @(negedge clk);
        end
        chk("dual load latency", 32'(lat), 32'd7);
        chk("dual load val", got_ld, 32'hFFFF8234);
        chk("dual load id", {29'b0, rid}, 32'd3);

        // rdy_in low for three cycles mid-load.
        lsb_issue(1'b0, 1'b1, 32'h100, 3'b010, 32'h0, 3'd6);
        lat = 0; got_ld = '0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 2) rdy_in = 1'b0;
            if (n == 4) chk("stall mem_a held", mem_a, 32'h101);
            if (n == 5) rdy_in = 1'b1;
            if (mem2lsb_load_en && lat == 0) begin lat = n; got_ld = mem2lsb_load_val; end
            @(negedge clk);
        end
        chk("stall load latency", 32'(lat), 32'd9);
        chk("stall load val", got_ld, 32'h84332211);

        // rdy_in low for one cycle mid-store: write strobe suppressed, beat resumes.
        w0 = wr_count;
        lsb_issue(1'b1, 1'b0, 32'h800, 3'b010, 32'hCAFEF00D, 3'd0);
        @(negedge clk);
        rdy_in = 1'b0;
        #1;
        chk("stall mem_wr gated", {31'b0, mem_wr}, 32'h0);
        @(negedge clk);
        rdy_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("stall store writes", 32'(wr_count - w0), 32'd4);
        do_load(32'h800, 3'b010, 3'd2, v, rid, lat);
        chk("stall store readback", v, 32'hCAFEF00D);

        // Asynchronous reset mid-store: only the first beat lands.
        lsb_issue(1'b1, 1'b0, 32'h700, 3'b010, 32'h44332211, 3'd0);
        @(negedge clk);
        rst_in = 1'b1;
        #1;
        chk("async rst mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("async rst busy", {31'b0, mem_busy}, 32'h0);
        @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        do_load(32'h700, 3'b010, 3'd0, v, rid, lat);
        chk("async rst partial", v, 32'h00000011);

        // IO-space byte store while the IO sink is full for three cycles.
        io_buffer_full = 1'b1; w0 = wr_count; first = 0;
        lsb_issue(1'b1, 1'b0, 32'h30000, 3'b000, 32'h00000077, 3'd0);
        for (int n = 1; n <= 10; n++) begin
            if (n >= 4) io_buffer_full = 1'b0;
            #1;
            if (mem_wr && first == 0) first = n;
            @(negedge clk);
        end
`ifdef MEM_ARB_IO_STALL_EN
        chk("io store first write", 32'(first), 32'd4);
`else
        chk("io store first write", 32'(first), 32'd1);
`endif
        chk("io store writes", 32'(wr_count - w0), 32'd1);
        do_load(32'h30000, 3'b100, 3'd5, v, rid, lat);
        chk("io store readback", v, 32'h00000077);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
